// File: rtl/io_rx_fifo.sv
// IO-mapped receive FIFO between the serial receiver and the Z80 IO bus.
// Data port at BASE_ADDR, status/control at BASE_ADDR+1, sticky overflow, level IRQ.
`timescale 1ns/1ps
module io_rx_fifo #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [7:0]  BASE_ADDR  = 8'h86
) (
  input  logic                  cpu_clk,
  input  logic                  n_RST,
  input  logic [7:0]            addr,
  input  logic                  ioreq,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  intreq,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [DEPTH_LOG2:0]   count_q, count_next;
  logic                  ovf, ovf_next, ie, ie_next;
  logic                  rd_stb_p0, rd_stb_p1, wr_stb_p0, wr_stb_p1;
  logic                  sel, empty, full, pop_stb, ctl_stb, flush;
  logic                  push_ok, pop_ok, ovf_set;
  logic [7:0]            status;
  logic                  unused_bits;

  assign sel       = ioreq & (addr[7:1] == BASE_ADDR[7:1]);
  assign rd_stb_p0 = sel & rd & ~addr[0];
  assign wr_stb_p0 = sel & wr & addr[0];
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  // One pop per CPU access: act on the falling edge of the data-read strobe.
  assign pop_stb   = rd_stb_p1 & ~rd_stb_p0;
  assign ctl_stb   = wr_stb_p0 & ~wr_stb_p1;
  assign flush     = ctl_stb & data_in[7];
  assign status    = {4'b0000, ie, ovf, full, ~empty};
  assign count     = count_q;
  assign unused_bits = ^{data_in[6:4], data_in[1:0]};

  always_comb begin
    pop_ok      = pop_stb & ~empty & ~flush;
    push_ok     = in_valid & (~full | pop_ok) & ~flush;
    ovf_set     = in_valid & full & ~pop_ok & ~flush;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count_q;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_ok) wr_ptr_next = wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr_next = rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_next = count_q + CNT_ONE;
        2'b01:   count_next = count_q - CNT_ONE;
        default: count_next = count_q;
      endcase
    end
    ie_next  = ctl_stb ? data_in[3] : ie;
    ovf_next = (ctl_stb & data_in[2]) ? 1'b0 : (ovf | ovf_set);
  end

  always_comb begin
    data_out = 8'h00;
    if (sel & rd) begin
      if (addr[0])     data_out = status;
      else if (!empty) data_out = mem[rd_ptr];
    end
  end

  // Control state: pointers, occupancy, flags and strobe history
  always_ff @(posedge cpu_clk or negedge n_RST) begin
    if (!n_RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      ovf       <= 1'b0;
      ie        <= 1'b0;
      intreq    <= 1'b0;
      rd_stb_p1 <= 1'b0;
      wr_stb_p1 <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      count_q   <= count_next;
      ovf       <= ovf_next;
      ie        <= ie_next;
      intreq    <= ie_next & (count_next != '0);
      rd_stb_p1 <= rd_stb_p0;
      wr_stb_p1 <= wr_stb_p0;
    end
  end

  // Storage: data only, no reset
  always_ff @(posedge cpu_clk) begin
    if (push_ok) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_io_rx_fifo.sv
// Directed testbench for io_rx_fifo: reset, pop-per-access, overflow, IRQ, full/flush corners.
`timescale 1ns/1ps
module tb_io_rx_fifo;

  logic       cpu_clk = 1'b0;
  logic       n_RST   = 1'b0;
  logic [7:0] addr    = 8'h00;
  logic       ioreq   = 1'b0;
  logic       rd      = 1'b0;
  logic       wr      = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       intreq;
  logic [4:0] count;

  int checks   = 0;
  int failures = 0;

  io_rx_fifo #(.DEPTH_LOG2(4), .BASE_ADDR(8'h86)) dut (
    .cpu_clk(cpu_clk), .n_RST(n_RST), .addr(addr), .ioreq(ioreq), .rd(rd), .wr(wr),
    .data_in(data_in), .data_out(data_out), .in_valid(in_valid), .in_data(in_data),
    .intreq(intreq), .count(count)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Read held for n cycles; returns first sampled value and whether it stayed stable.
  task automatic io_read(input logic [7:0] a, input int n, output logic [7:0] d, output bit stable);
    ioreq = 1'b1; rd = 1'b1; addr = a;
    #1;
    d = data_out;
    stable = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge cpu_clk);
      #1;
      if (data_out !== d) stable = 1'b0;
    end
    ioreq = 1'b0; rd = 1'b0;
    tick();
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    ioreq = 1'b1; wr = 1'b1; addr = a; data_in = d;
    tick();
    ioreq = 1'b0; wr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] d; bit s;
    n_RST = 1'b0;
    tick(); tick();
    n_RST = 1'b1;
    tick();
    io_read(8'h87, 1, d, s);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_status got=%h exp=00", d); end
    io_read(8'h86, 1, d, s);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", d); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (intreq !== 1'b0) begin failures++; $display("FAIL reset_intreq got=%b exp=0", intreq); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL unselected_data got=%h exp=00", data_out); end
  endtask

  task automatic test_basic();
    logic [7:0] d; bit s;
    logic [7:0] exp_b [3];
    int lens [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    lens[0] = 3; lens[1] = 1; lens[2] = 2;
    for (int i = 0; i < 3; i++) push(exp_b[i]);
    checks++; if (count !== 5'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", count); end
    io_read(8'h87, 1, d, s);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL basic_status got=%h exp=01", d); end
    for (int i = 0; i < 3; i++) begin
      io_read(8'h86, lens[i], d, s);
      checks++; if (d !== exp_b[i]) begin failures++; $display("FAIL basic_data%0d got=%h exp=%h", i, d, exp_b[i]); end
      checks++; if (!s) begin failures++; $display("FAIL basic_stable%0d got=unstable exp=stable", i); end
      checks++; if (count !== 5'(2 - i)) begin failures++; $display("FAIL basic_pop_count%0d got=%0d exp=%0d", i, count, 2 - i); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d; bit s;
    int errs;
    for (int i = 0; i <= 16; i++) push(8'(i));
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", count); end
    io_read(8'h87, 1, d, s);
    checks++; if (d !== 8'h07) begin failures++; $display("FAIL ovf_status got=%h exp=07", d); end
    io_write(8'h87, 8'h04);
    io_read(8'h87, 1, d, s);
    checks++; if (d !== 8'h03) begin failures++; $display("FAIL ovf_clear got=%h exp=03", d); end
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      io_read(8'h86, 1, d, s);
      if (d !== 8'(i)) begin errs++; $display("FAIL ovf_order%0d got=%h exp=%h", i, d, 8'(i)); end
    end
    checks++; if (errs != 0) failures++;
    for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      io_read(8'h86, 1, d, s);
      if (d !== 8'hA0 + 8'(i)) begin errs++; $display("FAIL wrap_order%0d got=%h exp=%h", i, d, 8'hA0 + 8'(i)); end
    end
    checks++; if (errs != 0) failures++;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL wrap_count got=%0d exp=0", count); end
  endtask

  task automatic test_irq();
    logic [7:0] d; bit s;
    io_write(8'h87, 8'h08);
    checks++; if (intreq !== 1'b0) begin failures++; $display("FAIL irq_empty got=%b exp=0", intreq); end
    push(8'h55);
    checks++; if (intreq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", intreq); end
    io_read(8'h87, 1, d, s);
    checks++; if (d !== 8'h09) begin failures++; $display("FAIL irq_status got=%h exp=09", d); end
    io_read(8'h86, 1, d, s);
    checks++; if (d !== 8'h55) begin failures++; $display("FAIL irq_data got=%h exp=55", d); end
    checks++; if (intreq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", intreq); end
    io_write(8'h87, 8'h00);
  endtask

  task automatic test_full_pop();
    logic [7:0] d; bit s;
    int errs;
    for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
    ioreq = 1'b1; rd = 1'b1; addr = 8'h86;
    tick(); tick();
    ioreq = 1'b0; rd = 1'b0;
    in_valid = 1'b1; in_data = 8'h99;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL fullpop_count got=%0d exp=16", count); end
    io_read(8'h87, 1, d, s);
    checks++; if (d !== 8'h03) begin failures++; $display("FAIL fullpop_status got=%h exp=03", d); end
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      io_read(8'h86, 1, d, s);
      if (d !== ((i == 15) ? 8'h99 : 8'h61 + 8'(i))) begin
        errs++; $display("FAIL fullpop_order%0d got=%h exp=%h", i, d, (i == 15) ? 8'h99 : 8'h61 + 8'(i));
      end
    end
    checks++; if (errs != 0) failures++;
    for (int i = 0; i < 3; i++) push(8'h10 + 8'(i));
    ioreq = 1'b1; wr = 1'b1; addr = 8'h87; data_in = 8'h80;
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    ioreq = 1'b0; wr = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    io_read(8'h87, 1, d, s);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL flush_status got=%h exp=00", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; bit s;
    io_write(8'h87, 8'h08);
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    checks++; if (intreq !== 1'b1 || count !== 5'd5) begin
      failures++; $display("FAIL rstmid_pre got=%b/%0d exp=1/5", intreq, count);
    end
    ioreq = 1'b1; rd = 1'b1; addr = 8'h86;
    tick();
    #2 n_RST = 1'b0;
    #1;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    checks++; if (intreq !== 1'b0) begin failures++; $display("FAIL rstmid_intreq got=%b exp=0", intreq); end
    ioreq = 1'b0; rd = 1'b0;
    tick();
    n_RST = 1'b1;
    tick(); tick();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL rstmid_release_count got=%0d exp=0", count); end
    io_read(8'h87, 1, d, s);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rstmid_status got=%h exp=00", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_irq();
    test_full_pop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
